arf_access_sequencer: RTL and testbench

Sequencer and arbiter for the address register file (PC, SP, AR). It accepts memory-address requests from five clients: fetch, push, pop, data access and jump. It grants one request at a time and drives the file's RegSel/FunSel/OutDSel/In controls through a fixed micro-sequence. It presents the resulting OutD address to memory under a valid/ready handshake.

---
 rtl/arf_ctrl_pkg.sv | 45 ++++
 rtl/arf_ctrl_arbiter.sv | 63 ++++++
 rtl/arf_access_sequencer.sv | 128 ++++++++++++
 tb/tb_arf_access_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arf_ctrl_pkg.sv
// rtl/arf_ctrl_pkg.sv - shared codes and types for the address register file sequencer
package arf_ctrl_pkg;

    // Register function codes driven on FunSel
    localparam logic [1:0] FS_DEC  = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_CLR  = 2'b11;

    // OutD source codes driven on OutDSel
    localparam logic [1:0] SEL_PC = 2'b00;
    localparam logic [1:0] SEL_SP = 2'b01;
    localparam logic [1:0] SEL_AR = 2'b10;

    // Bit positions inside RegSel
    localparam int RS_AR = 0;
    localparam int RS_SP = 1;
    localparam int RS_PC = 2;

    // Operation tags; also the bit positions of done and of the request vector
    localparam logic [2:0] TAG_FETCH = 3'd0;
    localparam logic [2:0] TAG_PUSH  = 3'd1;
    localparam logic [2:0] TAG_POP   = 3'd2;
    localparam logic [2:0] TAG_DATA  = 3'd3;
    localparam logic [2:0] TAG_JUMP  = 3'd4;

    localparam int N_CLIENTS = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SEL   = 2'd2,
        ST_ADDR  = 2'd3
    } state_t;

    // Which register an operation addresses memory with
    function automatic logic [1:0] tag_outsel(input logic [2:0] tag);
        case (tag)
            TAG_PUSH, TAG_POP: tag_outsel = SEL_SP;
            TAG_DATA:          tag_outsel = SEL_AR;
            default:           tag_outsel = SEL_PC;
        endcase
    endfunction

endpackage

// File: rtl/arf_ctrl_arbiter.sv
// rtl/arf_ctrl_arbiter.sv - fixed-priority request select with fetch starvation override
module arf_ctrl_arbiter
    import arf_ctrl_pkg::*;
#(
    parameter int FETCH_STARVE = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_CLIENTS-1:0] req,
    input  logic                 arb_en,
    output logic [N_CLIENTS-1:0] grant,
    output logic [2:0]           grant_tag
);

    // FETCH_STARVE below 1 is treated as a one-bit counter
    localparam int CW = (FETCH_STARVE < 1) ? 1 : $clog2(FETCH_STARVE + 1);
    localparam logic [CW-1:0] STARVE_LIMIT = CW'(FETCH_STARVE);

    logic [CW-1:0] starve_cnt;

    // Fixed priority jump > pop > push > data > fetch, unless fetch has waited long enough
    always_comb begin
        grant     = '0;
        grant_tag = TAG_FETCH;
        if (arb_en) begin
            if (req[TAG_FETCH] && starve_cnt == STARVE_LIMIT) begin
                grant[TAG_FETCH] = 1'b1;
                grant_tag        = TAG_FETCH;
            end else if (req[TAG_JUMP]) begin
                grant[TAG_JUMP] = 1'b1;
                grant_tag       = TAG_JUMP;
            end else if (req[TAG_POP]) begin
                grant[TAG_POP] = 1'b1;
                grant_tag      = TAG_POP;
            end else if (req[TAG_PUSH]) begin
                grant[TAG_PUSH] = 1'b1;
                grant_tag       = TAG_PUSH;
            end else if (req[TAG_DATA]) begin
                grant[TAG_DATA] = 1'b1;
                grant_tag       = TAG_DATA;
            end else if (req[TAG_FETCH]) begin
                grant[TAG_FETCH] = 1'b1;
                grant_tag        = TAG_FETCH;
            end
        end
    end

    // Count grants that pass over a waiting fetch; a fetch grant or idle fetch clears it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!req[TAG_FETCH]) begin
            starve_cnt <= '0;
        end else if (|grant) begin
            if (grant[TAG_FETCH]) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/arf_access_sequencer.sv
// rtl/arf_access_sequencer.sv - arbitrates address requests and sequences the address register file
module arf_access_sequencer
    import arf_ctrl_pkg::*;
#(
    parameter int FETCH_STARVE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_fetch,
    input  logic        req_push,
    input  logic        req_pop,
    input  logic        req_data,
    input  logic        req_jump,
    input  logic [15:0] data_addr,
    input  logic [15:0] jump_target,
    input  logic        mem_ready,
    output logic [4:0]  done,
    output logic        busy,
    output logic        addr_valid,
    output logic [2:0]  addr_tag,
    output logic [2:0]  RegSel,
    output logic [1:0]  FunSel,
    output logic [1:0]  OutDSel,
    output logic [31:0] arf_in
);

    state_t                 state_q, state_d;
    logic [2:0]             tag_q, tag_d;
    logic [N_CLIENTS-1:0]   req_vec;
    logic [N_CLIENTS-1:0]   grant;
    logic [2:0]             grant_tag;

    assign req_vec = {req_jump, req_data, req_pop, req_push, req_fetch};

    arf_ctrl_arbiter #(
        .FETCH_STARVE (FETCH_STARVE)
    ) u_arbiter (
        .clock     (clock),
        .reset     (reset),
        .req       (req_vec),
        .arb_en    (state_q == ST_IDLE),
        .grant     (grant),
        .grant_tag (grant_tag)
    );

    // Next state: fetch/push skip SETUP, jump ends after SETUP, ADDR waits for mem_ready
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    tag_d   = grant_tag;
                    state_d = (grant[TAG_FETCH] || grant[TAG_PUSH]) ? ST_SEL : ST_SETUP;
                end
            end
            ST_SETUP: state_d = (tag_q == TAG_JUMP) ? ST_IDLE : ST_SEL;
            ST_SEL:   state_d = ST_ADDR;
            ST_ADDR:  state_d = mem_ready ? ST_IDLE : ST_ADDR;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and owner tag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tag_q   <= TAG_FETCH;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

    // Register file controls decoded from state; only mem_ready and the load values reach outputs
    always_comb begin
        RegSel     = 3'b000;
        FunSel     = FS_DEC;
        OutDSel    = SEL_PC;
        arf_in     = 32'h0000_0000;
        done       = 5'b00000;
        addr_valid = 1'b0;
        case (state_q)
            ST_SETUP: begin
                case (tag_q)
                    TAG_POP: begin
                        RegSel[RS_SP] = 1'b1;
                        FunSel        = FS_INC;
                    end
                    TAG_DATA: begin
                        RegSel[RS_AR] = 1'b1;
                        FunSel        = FS_LOAD;
                        arf_in        = {16'h0000, data_addr};
                    end
                    TAG_JUMP: begin
                        RegSel[RS_PC]  = 1'b1;
                        FunSel         = FS_LOAD;
                        arf_in         = {16'h0000, jump_target};
                        done[TAG_JUMP] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_SEL: begin
                OutDSel = tag_outsel(tag_q);
            end
            ST_ADDR: begin
                OutDSel    = tag_outsel(tag_q);
                addr_valid = 1'b1;
                if (mem_ready) begin
                    done = 5'b00001 << tag_q;
                    if (tag_q == TAG_FETCH) begin
                        RegSel[RS_PC] = 1'b1;
                        FunSel        = FS_INC;
                    end else if (tag_q == TAG_PUSH) begin
                        RegSel[RS_SP] = 1'b1;
                        FunSel        = FS_DEC;
                    end
                end
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign addr_tag = tag_q;

endmodule

// File: tb/tb_arf_access_sequencer.sv
// tb/tb_arf_access_sequencer.sv - scoreboard bench with a register file model for arf_access_sequencer
module tb_arf_access_sequencer;
    import arf_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  req;
    logic [15:0] data_addr;
    logic [15:0] jump_target;
    logic        mem_ready;
    logic [4:0]  done;
    logic        busy;
    logic        addr_valid;
    logic [2:0]  addr_tag;
    logic [2:0]  RegSel;
    logic [1:0]  FunSel;
    logic [1:0]  OutDSel;
    logic [31:0] arf_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Register file model
    logic [15:0] pc_m, sp_m, ar_m, outd_m;
    logic        preset_en;
    logic [15:0] preset_pc, preset_sp, preset_ar;

    typedef struct {
        logic [4:0]  done;
        bit          has_addr;
        logic [15:0] addr;
        logic [2:0]  tag;
        int          start;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    arf_access_sequencer #(.FETCH_STARVE(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_fetch   (req[0]),
        .req_push    (req[1]),
        .req_pop     (req[2]),
        .req_data    (req[3]),
        .req_jump    (req[4]),
        .data_addr   (data_addr),
        .jump_target (jump_target),
        .mem_ready   (mem_ready),
        .done        (done),
        .busy        (busy),
        .addr_valid  (addr_valid),
        .addr_tag    (addr_tag),
        .RegSel      (RegSel),
        .FunSel      (FunSel),
        .OutDSel     (OutDSel),
        .arf_in      (arf_in)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] apply_fs(input logic [15:0] v, input logic [1:0] fs, input logic [15:0] ld);
        case (fs)
            2'b00:   apply_fs = v - 16'd1;
            2'b01:   apply_fs = v + 16'd1;
            2'b10:   apply_fs = ld;
            default: apply_fs = 16'h0000;
        endcase
    endfunction

    always @(posedge clock) begin
        if (preset_en) begin
            pc_m <= preset_pc;
            sp_m <= preset_sp;
            ar_m <= preset_ar;
        end else begin
            if (RegSel[2]) pc_m <= apply_fs(pc_m, FunSel, arf_in[15:0]);
            if (RegSel[1]) sp_m <= apply_fs(sp_m, FunSel, arf_in[15:0]);
            if (RegSel[0]) ar_m <= apply_fs(ar_m, FunSel, arf_in[15:0]);
        end
        case (OutDSel)
            2'b00:   outd_m <= pc_m;
            2'b01:   outd_m <= sp_m;
            2'b10:   outd_m <= ar_m;
            default: outd_m <= 16'h0000;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_op(input logic [2:0] tag, input logic [15:0] addr, input int lat);
        exp_t e;
        e.done     = 5'b00001 << tag;
        e.has_addr = (tag != TAG_JUMP);
        e.addr     = addr;
        e.tag      = tag;
        e.start    = cyc;
        e.lat      = lat;
        sbq.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every done pulse, checks stall stability
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            if (done != 5'b00000) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got %0b expected none", done);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("done_vec", {27'd0, done}, {27'd0, e.done});
                    if (e.has_addr) begin
                        check("addr_valid", {31'd0, addr_valid}, 32'd1);
                        check("outd", {16'd0, outd_m}, {16'd0, e.addr});
                        check("addr_tag", {29'd0, addr_tag}, {29'd0, e.tag});
                    end
                    if (e.lat >= 0) check("latency", cyc - e.start, e.lat);
                end
            end else if (addr_valid && !mem_ready && sbq.size() > 0) begin
                check("stall_regsel", {29'd0, RegSel}, 32'd0);
                check("stall_outd", {16'd0, outd_m}, {16'd0, sbq[0].addr});
            end
        end
    end

    // Drive requests; each drops on its done unless held. Called at posedge+1, returns at posedge+1.
    task automatic run(input logic [4:0] r, input int stalls, input logic [4:0] hold, input int hold_dones, input int budget);
        int n = 0;
        int stall_left = stalls;
        logic [4:0] hold_l = hold;
        bit finished = 0;
        req = r;
        for (int k = 0; k < budget && !finished; k++) begin
            if (addr_valid && stall_left > 0) begin
                mem_ready = 1'b0;
                stall_left--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clock);
            if (done != 5'b00000) n++;
            for (int i = 0; i < 5; i++) if (done[i] && !hold_l[i]) req[i] = 1'b0;
            if (hold_l != 5'b00000 && n >= hold_dones) begin
                req    = 5'b00000;
                hold_l = 5'b00000;
            end
            if (req == 5'b00000 && !busy) finished = 1;
            @(posedge clock);
            #1;
        end
        if (!finished) begin
            total++;
            bad++;
            $display("FAIL timeout: got busy=%0b req=%0b expected idle", busy, req);
            req = 5'b00000;
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        reset       = 1'b1;
        req         = 5'b00000;
        mem_ready   = 1'b1;
        data_addr   = 16'h0000;
        jump_target = 16'h0000;
        preset_en   = 1'b1;
        preset_pc   = 16'h0000;
        preset_sp   = 16'h0200;
        preset_ar   = 16'h0000;
        repeat (2) @(posedge clock);
        #1;
        preset_en = 1'b0;
        check("rst_done", {27'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr_valid", {31'd0, addr_valid}, 32'd0);
        check("rst_addr_tag", {29'd0, addr_tag}, 32'd0);
        check("rst_regsel", {29'd0, RegSel}, 32'd0);
        check("rst_funsel", {30'd0, FunSel}, 32'd0);
        check("rst_outdsel", {30'd0, OutDSel}, 32'd0);
        check("rst_arf_in", arf_in, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Jump loads PC, single cycle, no address phase
        jump_target = 16'h0100;
        expect_op(TAG_JUMP, 16'h0000, 1);
        run(5'b10000, 0, 5'b00000, 0, 50);
        check("pc_after_jump", {16'd0, pc_m}, 32'h0100);

        // Fetch addresses old PC then increments
        expect_op(TAG_FETCH, 16'h0100, 2);
        run(5'b00001, 0, 5'b00000, 0, 50);
        check("pc_after_fetch", {16'd0, pc_m}, 32'h0101);

        // Push with three stall cycles addresses pre-decrement SP
        expect_op(TAG_PUSH, 16'h0200, 5);
        run(5'b00010, 3, 5'b00000, 0, 50);
        check("sp_after_push", {16'd0, sp_m}, 32'h01FF);

        // Pop addresses post-increment SP
        expect_op(TAG_POP, 16'h0200, 3);
        run(5'b00100, 0, 5'b00000, 0, 50);
        check("sp_after_pop", {16'd0, sp_m}, 32'h0200);

        // Data loads AR
        data_addr = 16'hBEEF;
        expect_op(TAG_DATA, 16'hBEEF, 3);
        run(5'b01000, 0, 5'b00000, 0, 50);
        check("ar_after_data", {16'd0, ar_m}, 32'hBEEF);

        // All five together: jump, pop, push, data, fetch
        jump_target = 16'h3000;
        data_addr   = 16'h1234;
        expect_op(TAG_JUMP, 16'h0000, 1);
        expect_op(TAG_POP, 16'h0201, -1);
        expect_op(TAG_PUSH, 16'h0201, -1);
        expect_op(TAG_DATA, 16'h1234, -1);
        expect_op(TAG_FETCH, 16'h3000, -1);
        run(5'b11111, 0, 5'b00000, 0, 100);
        check("pc_after_all", {16'd0, pc_m}, 32'h3001);
        check("sp_after_all", {16'd0, sp_m}, 32'h0200);
        check("ar_after_all", {16'd0, ar_m}, 32'h1234);

        // Fetch and data held: four data grants then fetch, twice
        data_addr = 16'h0A0A;
        expect_op(TAG_DATA, 16'h0A0A, 3);
        for (int i = 0; i < 3; i++) expect_op(TAG_DATA, 16'h0A0A, -1);
        expect_op(TAG_FETCH, 16'h3001, -1);
        for (int i = 0; i < 4; i++) expect_op(TAG_DATA, 16'h0A0A, -1);
        expect_op(TAG_FETCH, 16'h3002, -1);
        run(5'b01001, 0, 5'b01001, 10, 400);
        check("pc_after_starve", {16'd0, pc_m}, 32'h3003);

        // Reset during pop SEL: immediate reset outputs, SP keeps SETUP increment
        req[2] = 1'b1;
        @(posedge clock);
        #1;
        check("pop_setup_regsel", {29'd0, RegSel}, 32'b010);
        @(posedge clock);
        #1;
        check("pop_sel_outdsel", {30'd0, OutDSel}, 32'b01);
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {27'd0, done}, 32'd0);
        check("midrst_regsel", {29'd0, RegSel}, 32'd0);
        check("midrst_outdsel", {30'd0, OutDSel}, 32'd0);
        check("midrst_addr_tag", {29'd0, addr_tag}, 32'd0);
        req = 5'b00000;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("sp_after_midrst", {16'd0, sp_m}, 32'h0201);
        check("idle_after_midrst", {31'd0, busy}, 32'd0);
        check("scoreboard_empty", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
